// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC select, imem request FSM and
// instruction register for the multi-cycle core. Optional perf
// counters are compiled in with `define FETCH_PERF_EN.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   PCWre, PCSrc        PC write enable, next-PC select
//   IRWre               fetch request (level, one fetch per level)
//   imm_ext, rs_data    branch offset source, jr target
//   imem_req/addr       request and registered fetch address
//   imem_rdata/valid    memory response (sampled only in FETCH)
//   pc, pc_plus4        current PC, PC+4 (jal link value)
//   ir, op..imm16       instruction register and decoded fields
//   fetch_busy          high exactly while in FETCH
//   fetch_count,        (FETCH_PERF_EN only) completed fetches and
//   stall_count          FETCH cycles without imem_valid, saturating
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PCWre,
    input  logic [1:0]      PCSrc,
    input  logic            IRWre,
    input  logic [PC_W-1:0] imm_ext,
    input  logic [PC_W-1:0] rs_data,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] ir,
    output logic [5:0]      op,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      sa,
    output logic [15:0]     imm16,
    output logic            fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ir;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_cap_addr;
    logic            w_load_ir;

    assign w_pc_plus4 = r_pc + {{(PC_W-3){1'b0}}, 3'd4};

    always_comb begin
        w_pc_nxt = w_pc_plus4;
        case (PCSrc)
            2'b00: w_pc_nxt = w_pc_plus4;
            2'b01: w_pc_nxt = w_pc_plus4 + (imm_ext << 2);
            2'b10: w_pc_nxt = rs_data;
            2'b11: w_pc_nxt = {w_pc_plus4[PC_W-1:28], r_ir[25:0], 2'b00};
            default: w_pc_nxt = w_pc_plus4;
        endcase
    end

    // HOLD waits for IRWre to drop so a long request level
    // produces exactly one fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_addr  = 1'b0;
        w_load_ir   = 1'b0;
        case (r_state)
            IDLE: begin
                if (IRWre) begin
                    w_cap_addr  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    w_load_ir   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!IRWre) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC[PC_W-1:0];
            r_ir    <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (PCWre)      r_pc   <= w_pc_nxt;
            if (w_cap_addr) r_addr <= r_pc;
            if (w_load_ir)  r_ir   <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load_ir && r_fetch_cnt != 32'hFFFF_FFFF)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (r_state == FETCH && !imem_valid &&
                r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;
`endif

    assign imem_req   = (r_state == FETCH);
    assign fetch_busy = (r_state == FETCH);
    assign imem_addr  = r_addr;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign ir         = r_ir;
    assign op         = r_ir[31:26];
    assign rs         = r_ir[25:21];
    assign rt         = r_ir[20:16];
    assign rd         = r_ir[15:11];
    assign sa         = r_ir[10:6];
    assign imm16      = r_ir[15:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage that sits directly upstream of the multi-cycle control unit. It owns the program counter and next-PC selection.
- It issues instruction-memory requests and holds the instruction register. It supplies op and the decoded instruction fields to the control unit and datapath.
- It consumes the control unit's PCWre, PCSrc and IRWre. It returns fetch_busy so the control unit can hold its state advance while memory is slow.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, width of PC, addresses and data.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, active-high, synchronous.
- PCWre  in  1  PC write enable.
- PCSrc  in  2  next-PC select.
- IRWre  in  1  fetch request (instruction register write enable).
- imm_ext  in  32  sign/zero-extended immediate from the extender.
- rs_data  in  32  register-file read port A, the jr target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  registered fetch address.
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  imem_rdata valid; only sampled in FETCH.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational; used as the jal link value.
- ir  out  32  instruction register.
- op  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- sa  out  5  ir[10:6].
- imm16  out  16  ir[15:0].
- fetch_busy  out  1  high while a fetch is outstanding.

Behaviour:
- Reset (RST=1 at a rising edge), all in the same cycle:
  - pc=RESET_PC, ir=0, imem_addr=0, imem_req=0, fetch_busy=0, state=IDLE.
  - Reset overrides everything, including a fetch in flight; a late imem_valid is ignored.
- Next PC, all arithmetic mod 2^32:
  - PCSrc 00: pc+4.
  - PCSrc 01: pc+4+(imm_ext<<2).
  - PCSrc 10: rs_data.
  - PCSrc 11: {pc_plus4[31:28], ir[25:0], 2'b00}.
- PC update:
  - When PCWre=1 at an edge, pc<=next PC. Otherwise pc holds; halt relies on PCWre never rising.
  - PC updates are independent of fetch state. imem_addr is captured at request time, so a PC write during FETCH does not disturb the in-flight fetch.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: if IRWre=1, imem_addr<=pc and go to FETCH. Else stay.
  - FETCH:
    - imem_req=1 and fetch_busy=1; imem_addr is held stable.
    - If imem_valid=1: ir<=imem_rdata and go to HOLD. imem_req and fetch_busy drop in the next cycle.
    - Otherwise stay; there is no timeout.
  - HOLD: ir stable. When IRWre=0, go to IDLE. While IRWre stays high, stay in HOLD, so one long IRWre level never causes a refetch.
- Latency and signal rules:
  - Minimum latency is 2 edges from IRWre sampled in IDLE to the new ir (zero-wait memory).
  - imem_valid in IDLE or HOLD is ignored.
  - fetch_busy is registered-state decode: high exactly in FETCH.
  - Decoded fields are combinational from ir.
  - ir changes only on the FETCH->HOLD edge or on reset.

Optional Feature:
- FETCH_PERF_EN defined adds two outputs, fetch_count[31:0] and stall_count[31:0]. Both reset to 0 and both saturate at 32'hFFFF_FFFF.
  - fetch_count increments on each FETCH->HOLD transition.
  - stall_count increments each cycle in FETCH with imem_valid=0.
- FETCH_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h100, then IRWre pulse with zero-wait memory returning 32'h0000_2020 -> imem_addr=32'h100, ir=32'h0000_2020 two edges after IRWre, op=0, rd=5'h04.
- pc=32'h200, imm_ext=32'hFFFF_FFFE, PCSrc=01, PCWre pulse -> pc=32'h1FC; PCSrc=00 from 32'h1FC -> pc=32'h200.
- jr: PCSrc=10, rs_data=32'h0000_3000 -> pc=32'h3000.
- j: pc=32'hA000_0040, ir[25:0]=26'h0000010, PCSrc=11 -> pc=32'hA000_0040.
- Memory holding imem_valid low for 3 cycles -> fetch_busy high for 4 cycles, imem_addr stable throughout. A PCWre pulse mid-fetch changes pc but not imem_addr; with FETCH_PERF_EN, stall_count=3 and fetch_count=1.
- RST asserted during FETCH, with imem_valid rising in the same cycle -> ir=0, state IDLE, pc=RESET_PC, imem_req=0 next cycle. Holding IRWre high for 5 cycles after a completed fetch -> exactly one fetch.
